// File: rtl/cdr_phase_controller.sv
// CDR loop controller: bang-bang votes -> windowed decision -> 9-bit PI phase code (optional integral path: CDR_FREQ_TRACK_EN).
// Latency: closing vote sampled at edge N, phase_shift/update/locked/freq_acc change at edge N+1.
// Backpressure: none; every valid vote is consumed, votes are discarded only while freeze is high.
module cdr_phase_controller #(
    parameter int VOTE_WINDOW = 16,
    parameter int KP_STEP     = 1,
    parameter int KI_SHIFT    = 4,
    parameter int LOCK_COUNT  = 64,
    parameter int FREQ_W      = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vote_valid,
    input  logic                     early,
    input  logic                     late,
    input  logic                     freeze,
    output logic [8:0]               phase_shift,
    output logic                     update,
    output logic                     locked,
    output logic signed [FREQ_W-1:0] freq_acc
);

    localparam int CNT_W = $clog2(VOTE_WINDOW);
    localparam int NET_W = CNT_W + 2;
    localparam int LCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] VCNT_LAST = CNT_W'(VOTE_WINDOW - 1);
    localparam logic [NET_W-1:0] QUIET_MAX = NET_W'(VOTE_WINDOW / 4);
    localparam logic [NET_W-1:0] SLIP_MIN  = NET_W'((3 * VOTE_WINDOW) / 4);
    localparam logic [LCK_W-1:0] LOCK_TGT  = LCK_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // Loop state
    state_t                    state_q, state_d;
    state_t                    resume_q, resume_d;
    state_t                    cur_mode, next_mode;
    logic [CNT_W-1:0]          vcnt_q, vcnt_d;
    logic signed [NET_W-1:0]   net_q, net_d;
    logic signed [NET_W-1:0]   vote_w, net_sum;
    logic                      win_vld_q, win_vld_d;
    logic signed [NET_W-1:0]   win_net_q, win_net_d;
    logic [8:0]                phase_q, phase_d;
    logic                      update_q, update_d;
    logic                      locked_q, locked_d;
    logic [LCK_W-1:0]          lock_cnt_q, lock_cnt_d;
    logic signed [FREQ_W-1:0]  freq_cur;

    // Decision arithmetic
    int                        gain;
    int                        prop;
    int                        integ;
    int                        step_i;
    logic [NET_W-1:0]          net_abs;
    logic                      quiet;

`ifdef CDR_FREQ_TRACK_EN
    localparam logic signed [FREQ_W-1:0] FREQ_MAX = {1'b0, {(FREQ_W-1){1'b1}}};
    localparam logic signed [FREQ_W-1:0] FREQ_MIN = -FREQ_MAX;

    logic signed [FREQ_W-1:0]  freq_q, freq_d;

    assign freq_cur = freq_q;

    // Integral accumulator follows the window decision and saturates symmetrically
    always_comb begin
        freq_d = freq_q;
        if (win_vld_q) begin
            if ((win_net_q > 0) && (freq_q != FREQ_MAX)) begin
                freq_d = freq_q + 1'b1;
            end else if ((win_net_q < 0) && (freq_q != FREQ_MIN)) begin
                freq_d = freq_q - 1'b1;
            end
        end
    end

    // Integral accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q <= '0;
        end else begin
            freq_q <= freq_d;
        end
    end
`else
    // Proportional-only loop: the integral term is a constant zero
    assign freq_cur = '0;
`endif

    assign freq_acc    = freq_cur;
    assign phase_shift = phase_q;
    assign update      = update_q;
    assign locked      = locked_q;

    // Vote window: accumulate weights, capture the final net on the closing vote
    always_comb begin
        vote_w = '0;
        if (early && !late) begin
            vote_w = NET_W'(1);
        end else if (late && !early) begin
            vote_w = '1;
        end
        net_sum   = net_q + vote_w;
        vcnt_d    = vcnt_q;
        net_d     = net_q;
        win_vld_d = 1'b0;
        win_net_d = win_net_q;
        if (freeze) begin
            // Partial window is thrown away; a closing vote here takes no decision
            vcnt_d = '0;
            net_d  = '0;
        end else if (vote_valid) begin
            if (vcnt_q == VCNT_LAST) begin
                win_vld_d = 1'b1;
                win_net_d = net_sum;
                vcnt_d    = '0;
                net_d     = '0;
            end else begin
                vcnt_d = vcnt_q + 1'b1;
                net_d  = net_sum;
            end
        end
    end

    // Decision stage: apply the captured window to phase code, lock counter and mode
    always_comb begin
        cur_mode  = (state_q == ST_HOLD) ? resume_q : state_q;
        next_mode = cur_mode;
        gain      = (cur_mode == ST_TRACK) ? KP_STEP : 4 * KP_STEP;
        prop      = 0;
        if (win_net_q > 0) begin
            prop = gain;
        end else if (win_net_q < 0) begin
            prop = -gain;
        end
        integ      = int'(freq_cur >>> KI_SHIFT);
        step_i     = prop + integ;
        net_abs    = win_net_q[NET_W-1] ? -win_net_q : win_net_q;
        quiet      = (net_abs <= QUIET_MAX);
        phase_d    = phase_q;
        update_d   = 1'b0;
        lock_cnt_d = lock_cnt_q;
        if (win_vld_q) begin
            // Low 9 bits of the sum give modulo-512 wrap in both directions
            phase_d  = phase_q + step_i[8:0];
            update_d = (step_i != 0);
            if (!quiet) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LOCK_TGT) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
            if ((cur_mode == ST_ACQUIRE) && (lock_cnt_d == LOCK_TGT)) begin
                next_mode = ST_TRACK;
            end else if ((cur_mode == ST_TRACK) && (net_abs >= SLIP_MIN)) begin
                next_mode  = ST_ACQUIRE;
                lock_cnt_d = '0;
            end
        end
        // HOLD remembers the underlying mode so release resumes it
        state_d  = freeze ? ST_HOLD : next_mode;
        resume_d = next_mode;
        locked_d = (next_mode == ST_TRACK);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACQUIRE;
            resume_q   <= ST_ACQUIRE;
            vcnt_q     <= '0;
            net_q      <= '0;
            win_vld_q  <= 1'b0;
            win_net_q  <= '0;
            phase_q    <= '0;
            update_q   <= 1'b0;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            vcnt_q     <= vcnt_d;
            net_q      <= net_d;
            win_vld_q  <= win_vld_d;
            win_net_q  <= win_net_d;
            phase_q    <= phase_d;
            update_q   <= update_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

endmodule

// File: tb/tb_cdr_phase_controller.sv
// Bench for cdr_phase_controller: directed scenarios plus randomized votes.
// Expected updates come from a window-level reference model and are queued for a monitor.
// The monitor pops one record per update pulse and compares phase, lock and frequency.
module tb_cdr_phase_controller;

    localparam int VW   = 16;
    localparam int KP   = 1;
    localparam int KI   = 4;
    localparam int LCKN = 64;
    localparam int FW   = 12;
    localparam int FMAX = (1 << (FW - 1)) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 vote_valid = 1'b0;
    logic                 early = 1'b0;
    logic                 late = 1'b0;
    logic                 freeze = 1'b0;
    logic [8:0]           phase_shift;
    logic                 update;
    logic                 locked;
    logic signed [FW-1:0] freq_acc;

    cdr_phase_controller #(
        .VOTE_WINDOW(VW),
        .KP_STEP    (KP),
        .KI_SHIFT   (KI),
        .LOCK_COUNT (LCKN),
        .FREQ_W     (FW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vote_valid (vote_valid),
        .early      (early),
        .late       (late),
        .freeze     (freeze),
        .phase_shift(phase_shift),
        .update     (update),
        .locked     (locked),
        .freq_acc   (freq_acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int lck;
        int freq;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   upd_seen = 0;

    // Reference model state (window level)
    int m_phase, m_freq, m_locked, m_run, m_net, m_cnt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_freq = 0; m_locked = 0; m_run = 0; m_net = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic close_window();
        int d, g, integ, step, absn;
        exp_t e;
        d = (m_net > 0) ? 1 : ((m_net < 0) ? -1 : 0);
        g = m_locked ? KP : 4 * KP;
`ifdef CDR_FREQ_TRACK_EN
        integ = floor_div(m_freq, 1 << KI);
        m_freq = m_freq + d;
        if (m_freq > FMAX) m_freq = FMAX;
        if (m_freq < -FMAX) m_freq = -FMAX;
`else
        integ = 0;
`endif
        step = d * g + integ;
        m_phase = (((m_phase + step) % 512) + 512) % 512;
        absn = (m_net < 0) ? -m_net : m_net;
        if (absn <= VW / 4) m_run++;
        else m_run = 0;
        if (!m_locked && m_run >= LCKN) begin
            m_locked = 1;
        end else if (m_locked && absn >= (3 * VW) / 4) begin
            m_locked = 0;
            m_run = 0;
        end
        if (step != 0) begin
            e.phase = m_phase; e.lck = m_locked; e.freq = m_freq;
            exp_q.push_back(e);
        end
    endtask

    // One cycle of stimulus; the DUT samples it at the next rising edge
    task automatic drive(input bit v, input bit e, input bit l, input bit f);
        @(posedge clk);
        #1;
        vote_valid = v; early = e; late = l; freeze = f;
        if (f) begin
            m_net = 0; m_cnt = 0;
        end else if (v) begin
            if (e && !l) m_net++;
            else if (l && !e) m_net--;
            m_cnt++;
            if (m_cnt == VW) begin
                close_window();
                m_net = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic votes(input int n, input bit e, input bit l);
        for (int i = 0; i < n; i++) drive(1'b1, e, l, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0; vote_valid = 1'b0; early = 1'b0; late = 1'b0; freeze = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: each update pulse must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && update) begin
            exp_t e;
            upd_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_update actual=1 expected=0 phase=%0d at %0t", phase_shift, $time);
            end else begin
                e = exp_q.pop_front();
                check("upd_phase", int'(phase_shift), e.phase);
                check("upd_locked", int'(locked), e.lck);
                check("upd_freq", int'(freq_acc), e.freq);
            end
        end
    end

    initial begin
        int u0, bias, frz_left;
        bit v, e, l, f;
        model_reset();
        #2;
        check("rst_phase", int'(phase_shift), 0);
        check("rst_update", int'(update), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_freq", int'(freq_acc), 0);
        release_reset();

        // One early window from reset
        votes(VW, 1'b1, 1'b0);
        idle(3);
        check("early_phase", int'(phase_shift), 4);
`ifdef CDR_FREQ_TRACK_EN
        check("early_freq", int'(freq_acc), 1);
`else
        check("early_freq", int'(freq_acc), 0);
`endif

        // Reset in the middle of a window
        votes(5, 1'b1, 1'b0);
        do_reset();
        check("midrst_phase", int'(phase_shift), 0);
        check("midrst_update", int'(update), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_freq", int'(freq_acc), 0);
        release_reset();

        // Wrap below zero and back above 511
        votes(VW, 1'b0, 1'b1);
        idle(3);
        check("wrap_low", int'(phase_shift), 508);
        votes(2 * VW, 1'b1, 1'b0);
        idle(3);
`ifdef CDR_FREQ_TRACK_EN
        check("wrap_high", int'(phase_shift), m_phase);
`else
        check("wrap_high", int'(phase_shift), 4);
`endif

        // Lock after 64 quiet windows, then a slip
        do_reset();
        release_reset();
        for (int w = 0; w < LCKN; w++) begin
            for (int k = 0; k < VW / 2; k++) begin
                drive(1'b1, 1'b1, 1'b0, 1'b0);
                drive(1'b1, 1'b0, 1'b1, 1'b0);
            end
        end
        idle(3);
        check("lock_locked", int'(locked), 1);
        check("lock_phase", int'(phase_shift), 0);
        votes(VW, 1'b1, 1'b0);
        idle(3);
        check("slip_phase", int'(phase_shift), 1);
        check("slip_locked", int'(locked), 0);

        // Freeze discards a partial window
        do_reset();
        release_reset();
        u0 = upd_seen;
        votes(VW / 2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        votes(VW, 1'b0, 1'b1);
        idle(3);
        check("freeze_phase", int'(phase_shift), 508);
        check("freeze_updates", upd_seen - u0, 1);

`ifdef CDR_FREQ_TRACK_EN
        // Integral saturation
        do_reset();
        release_reset();
        votes(2100 * VW, 1'b1, 1'b0);
        idle(3);
        check("sat_freq", int'(freq_acc), FMAX);
`endif

        // Randomized votes with freeze bursts
        do_reset();
        release_reset();
        bias = 0;
        frz_left = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 1000 == 0) bias = $urandom_range(0, 3);
            v = ($urandom_range(0, 99) < 85);
            case (bias)
                0: begin e = ((i % 2) == 0); l = !e; end
                1: begin e = ($urandom_range(0, 99) < 80); l = ($urandom_range(0, 99) < 15); end
                2: begin e = ($urandom_range(0, 99) < 15); l = ($urandom_range(0, 99) < 80); end
                default: begin e = $urandom_range(0, 1); l = $urandom_range(0, 1); end
            endcase
            if (frz_left > 0) begin
                frz_left--;
                f = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                frz_left = $urandom_range(0, 3);
                f = 1'b1;
            end else begin
                f = 1'b0;
            end
            drive(v, e, l, f);
        end
        idle(4);
        check("rand_drain", exp_q.size(), 0);
        check("rand_phase", int'(phase_shift), m_phase);
        check("rand_locked", int'(locked), m_locked);
        check("rand_freq", int'(freq_acc), m_freq);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
